// File: rtl/cla_nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial CLA adder/subtractor.
// Includes the slice width, the FSM state type and the nibble propagate/generate helper.
package cla_nibble_serial_addsub_pkg;

    // Width of the single carry-lookahead slice reused every RUN cycle
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [NIB_W-1:0] p;
        logic [NIB_W-1:0] g;
    } pg_t;

    // Per-bit propagate (a^b) and generate (a&b) for one nibble
    function automatic pg_t nib_pg(input logic [NIB_W-1:0] a, input logic [NIB_W-1:0] b);
        pg_t r;
        r.p = a ^ b;
        r.g = a & b;
        return r;
    endfunction

endpackage

// File: rtl/cla_nibble_serial_addsub_if.sv
// Operand/result valid-ready bus of the nibble-serial adder/subtractor.
// The master side is the operand producer plus the result consumer; the slave side is the block.
interface cla_nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_cb;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_res, out_cb, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_res, out_cb, out_ovf, out_zero
    );
endinterface

// File: rtl/cla_nibble_serial_addsub_cla.sv
// Combinational 4-bit carry-lookahead slice.
// Also exposes the carry into bit 3, so the caller can derive signed overflow on the top nibble.
module cla_nibble_serial_addsub_cla
    import cla_nibble_serial_addsub_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c3
);
    pg_t              w_pg;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W-1:0] w_g;
    logic [NIB_W:0]   w_c;

    assign w_pg = nib_pg(i_a, i_b);
    assign w_p  = w_pg.p;
    assign w_g  = w_pg.g;

    // All carries are expanded directly from P/G and cin, so there is no ripple inside the slice
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[NIB_W-1:0];
    assign o_cout = w_c[NIB_W];
    assign o_c3   = w_c[NIB_W-1];

endmodule

// File: rtl/cla_nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit CLA slice.
// It processes one nibble per clock, LSB first, and chains the carry through a register.
// Subtraction is done as A + ~B + 1: B is inverted when the operands are accepted, and the carry is seeded with 1.
module cla_nibble_serial_addsub
    import cla_nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                         clk,
    input  logic                         rst,
    cla_nibble_serial_addsub_if.slave    bus
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_sub;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_res;
    logic             r_out_cb;
    logic             r_out_ovf;
    logic             r_out_zero;

    logic [NIB_W-1:0] w_a_nibs [NIB];
    logic [NIB_W-1:0] w_b_nibs [NIB];
    logic [NIB_W-1:0] w_a_nib;
    logic [NIB_W-1:0] w_b_nib;
    logic [NIB_W-1:0] w_sum;
    logic             w_cout;
    logic             w_c3;
    logic [WIDTH-1:0] w_res_next;
    logic             w_in_ready;

    // Split the operands into nibbles, and merge the current slice sum into the partial result
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign w_a_nibs[gi] = r_a[gi*NIB_W +: NIB_W];
        assign w_b_nibs[gi] = r_b[gi*NIB_W +: NIB_W];
        assign w_res_next[gi*NIB_W +: NIB_W] =
            (r_cnt == CNT_W'(gi)) ? w_sum : r_res[gi*NIB_W +: NIB_W];
    end

    assign w_a_nib = w_a_nibs[r_cnt];
    assign w_b_nib = w_b_nibs[r_cnt];

    cla_nibble_serial_addsub_cla u_cla (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_c3   (w_c3)
    );

    // Forced low while rst is asserted, so a producer never sees ready during reset
    assign w_in_ready = (r_state == IDLE) && !rst;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_res   = r_out_res;
    assign bus.out_cb    = r_out_cb;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_zero  = r_out_zero;

    // Control FSM and datapath registers; outputs change only on reset or on DONE entry/exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_cb    <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready is implicitly high here, because rst is low and the state is IDLE
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        r_carry <= bus.in_sub;
                        r_sub   <= bus.in_sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    if (r_cnt == LAST) begin
                        // On the top nibble, the slice carries give the unsigned carry/borrow and signed overflow
                        r_out_res   <= w_res_next;
                        r_out_cb    <= w_cout ^ r_sub;
                        r_out_ovf   <= w_c3 ^ w_cout;
                        r_out_zero  <= (w_res_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_addsub.sv
// Self-checking bench for cla_nibble_serial_addsub (WIDTH=16).
// It applies a directed vector table, then backpressure and mid-RUN reset sequences, then random operations with gaps.
module tb_cla_nibble_serial_addsub;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        cb;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [12];

    cla_nibble_serial_addsub_if #(.WIDTH(WIDTH)) bus();

    cla_nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Golden reference computed with full-width arithmetic
    task automatic golden(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output logic [15:0] res, output logic cb, output logic ovf,
                          output logic zero);
        logic [16:0] s;
        s    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        res  = s[15:0];
        cb   = s[16];
        ovf  = sub ? ((a[15] != b[15]) && (res[15] != a[15]))
                   : ((a[15] == b[15]) && (res[15] != a[15]));
        zero = (res == 16'h0000);
    endtask

    // One transaction, called and returning at a negedge. The operands are scrambled after acceptance.
    // If poke is set, in_valid is held high for one cycle while the block is busy.
    // bp is the number of cycles out_ready stays low once the result is valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input int pre_gap, input int bp, input logic poke,
                          output logic [15:0] res, output logic cb, output logic ovf,
                          output logic zero, output int lat);
        int n;
        int t;
        int bad;
        repeat (pre_gap) @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_in_ready", bus.in_ready, 1);
        bus.out_ready = (bp == 0);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = sub;
        t = cyc;
        @(negedge clk);
        check("busy_in_ready", bus.in_ready, 0);
        bus.in_valid = poke;
        bus.in_a     = ~a;
        bus.in_b     = a ^ b;
        bus.in_sub   = ~sub;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        check("wait_out_valid", bus.out_valid, 1);
        lat  = cyc - t;
        res  = bus.out_res;
        cb   = bus.out_cb;
        ovf  = bus.out_ovf;
        zero = bus.out_zero;
        if (bp > 0) begin
            bad = 0;
            repeat (bp) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || bus.out_res !== res || bus.in_ready !== 1'b0)
                    bad++;
            end
            check("bp_hold", bad, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", bus.out_valid, 0);
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] er;
        logic        c, o, z, ec, eo, ez;
        int          lat;
        int          seen;

        vecs[0]  = '{16'h1234, 16'h0235, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{16'h0001, 16'h8000, 1'b1, 16'h8001, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_res", bus.out_res, 0);
        check("rst_flags", {bus.out_cb, bus.out_ovf, bus.out_zero}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, i % 3, 0, logic'(i % 2), r, c, o, z, lat);
            $display("vec %0d a=%h b=%h sub=%b res=%h cb=%b ovf=%b zero=%b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].sub, r, c, o, z, lat);
            check("vec_res", r, vecs[i].res);
            check("vec_cb", c, vecs[i].cb);
            check("vec_ovf", o, vecs[i].ovf);
            check("vec_zero", z, vecs[i].zero);
            check("vec_latency", lat, NIB + 1);
            check("vec_hold_res", bus.out_res, vecs[i].res);
        end

        // Hold out_ready low for 10 cycles with the result pending
        run_op(16'h1234, 16'h0235, 1'b1, 0, 10, 1'b0, r, c, o, z, lat);
        $display("bp a=1234 b=0235 sub=1 res=%h cb=%b ovf=%b zero=%b lat=%0d", r, c, o, z, lat);
        check("bp_res", r, 16'h0FFF);
        check("bp_latency", lat, NIB + 1);
        check("bp_post_in_ready", bus.in_ready, 1);
        check("bp_hold_after", bus.out_res, 16'h0FFF);

        // Assert reset on the 2nd RUN cycle after leaving nonzero outputs behind
        run_op(16'h0000, 16'h0001, 1'b1, 0, 0, 1'b0, r, c, o, z, lat);
        check("pre_rst_cb", c, 1);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h1111;
        bus.in_sub   = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_valid", bus.out_valid, 0);
        check("midrun_rst_res", bus.out_res, 0);
        check("midrun_rst_cb", bus.out_cb, 0);
        check("midrun_rst_in_ready", bus.in_ready, 0);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrun_discarded", seen, 0);
        run_op(16'h1234, 16'h1111, 1'b0, 0, 0, 1'b0, r, c, o, z, lat);
        $display("post_rst a=1234 b=1111 sub=0 res=%h cb=%b ovf=%b zero=%b lat=%0d", r, c, o, z, lat);
        check("post_rst_res", r, 16'h2345);
        check("post_rst_flags", {c, o, z}, 0);
        check("post_rst_latency", lat, NIB + 1);

        // Random operations with random idle gaps and backpressure
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        s;
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            golden(a, b, s, er, ec, eo, ez);
            run_op(a, b, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), r, c, o, z, lat);
            $display("rnd %0d a=%h b=%h sub=%b res=%h cb=%b ovf=%b zero=%b", i, a, b, s, r, c, o, z);
            check("rnd_res", r, er);
            check("rnd_flags", {c, o, z}, {ec, eo, ez});
            check("rnd_latency", lat, NIB + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
